// File: rtl/alu_control_seq.sv
// Registered ALU control for the ID/EX boundary: decodes ALUOp/funct into an
// ALU select and sequences multi-cycle MULT/DIV launches with an upstream stall.
module alu_control_seq #(
    parameter int ALUOP_WIDTH  = 3,
    parameter int FUNCT_WIDTH  = 6,
    parameter int OPER_WIDTH   = 4,
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic                   flush_i,
    input  logic [ALUOP_WIDTH-1:0] ALUOp,
    input  logic [FUNCT_WIDTH-1:0] ALUFunction,
    output logic [OPER_WIDTH-1:0]  ALUOperation,
    output logic                   valid_o,
    output logic                   Illegal,
    output logic                   MDUStart,
    output logic [1:0]             MDUOp,
    output logic                   MDUDone,
    output logic                   Stall
);

    localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef logic [ALUOP_WIDTH-1:0] aluop_t;
    typedef logic [FUNCT_WIDTH-1:0] funct_t;
    typedef logic [CNT_W-1:0]       cnt_t;
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] OP_NOP = 4'b1001;
    localparam logic [3:0] OP_MDU = 4'b1100;
    localparam aluop_t A_RTYPE = aluop_t'(3'b111);
    localparam aluop_t A_ADDI  = aluop_t'(3'b100);
    localparam aluop_t A_ORI   = aluop_t'(3'b001);
    localparam aluop_t A_ANDI  = aluop_t'(3'b011);
    localparam aluop_t A_LUI   = aluop_t'(3'b101);
    localparam aluop_t A_BR    = aluop_t'(3'b010);
    localparam cnt_t   MULT_LOAD = cnt_t'(MULT_LATENCY - 1);
    localparam cnt_t   DIV_LOAD  = cnt_t'(DIV_LATENCY - 1);

    state_t     r_state, w_state_next;
    logic [3:0] r_op, w_op_next, w_dec_op;
    logic       r_valid, w_valid_next;
    logic       r_illegal, w_illegal_next, w_dec_illegal;
    logic       r_start, w_start_next;
    logic [1:0] r_mdu_op, w_mdu_op_next;
    logic       r_done, w_done_next;
    cnt_t       r_cnt, w_cnt_next, w_cnt_load;
    logic       w_dec_mdu;

    // Decode of the instruction currently on the inputs.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_dec_op      = OP_NOP;
        w_dec_illegal = 1'b1;
        w_dec_mdu     = 1'b0;
        case (ALUOp)
            A_RTYPE: begin
                w_dec_illegal = 1'b0;
                case (ALUFunction)
                    funct_t'(6'b100100): w_dec_op = 4'b0000;
                    funct_t'(6'b100101): w_dec_op = 4'b0001;
                    funct_t'(6'b100111): w_dec_op = 4'b0010;
                    funct_t'(6'b100000): w_dec_op = 4'b0011;
                    funct_t'(6'b100010): w_dec_op = 4'b0100;
                    funct_t'(6'b000000): w_dec_op = 4'b0110;
                    funct_t'(6'b000010): w_dec_op = 4'b0111;
                    funct_t'(6'b101010): w_dec_op = 4'b1000;
                    funct_t'(6'b010000): w_dec_op = 4'b1010;
                    funct_t'(6'b010010): w_dec_op = 4'b1011;
                    funct_t'(6'b011000), funct_t'(6'b011001),
                    funct_t'(6'b011010), funct_t'(6'b011011): begin
                        w_dec_op  = OP_MDU;
                        w_dec_mdu = 1'b1;
                    end
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            A_ADDI:  begin w_dec_op = 4'b0011; w_dec_illegal = 1'b0; end
            A_ORI:   begin w_dec_op = 4'b0001; w_dec_illegal = 1'b0; end
            A_ANDI:  begin w_dec_op = 4'b0000; w_dec_illegal = 1'b0; end
            A_LUI:   begin w_dec_op = 4'b0101; w_dec_illegal = 1'b0; end
            A_BR:    begin w_dec_op = 4'b0100; w_dec_illegal = 1'b0; end
            default: ;
        endcase
    end

    // funct[1] separates DIV/DIVU from MULT/MULTU; funct[1:0] is the MDUOp encoding.
    assign w_cnt_load = ALUFunction[1] ? DIV_LOAD : MULT_LOAD;

    always_comb begin
        w_state_next   = r_state;
        w_op_next      = r_op;
        w_valid_next   = r_valid;
        w_illegal_next = r_illegal;
        w_start_next   = 1'b0;
        w_mdu_op_next  = r_mdu_op;
        w_done_next    = 1'b0;
        w_cnt_next     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    w_op_next      = w_dec_op;
                    w_valid_next   = 1'b1;
                    w_illegal_next = w_dec_illegal;
                    if (w_dec_mdu) begin
                        w_start_next  = 1'b1;
                        w_mdu_op_next = ALUFunction[1:0];
                        w_cnt_next    = w_cnt_load;
                        w_done_next   = (w_cnt_load == '0);
                        w_state_next  = S_BUSY;
                    end
                end else begin
                    w_op_next      = OP_NOP;
                    w_valid_next   = 1'b0;
                    w_illegal_next = 1'b0;
                end
            end
            S_BUSY: begin
                if (flush_i) w_valid_next = 1'b0;
                // Done is registered one count early so it lines up with the last Stall cycle.
                if (r_cnt != '0) begin
                    w_cnt_next  = r_cnt - cnt_t'(1);
                    w_done_next = (r_cnt == cnt_t'(1));
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NOP;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_start   <= 1'b0;
            r_mdu_op  <= 2'b00;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_op      <= w_op_next;
            r_valid   <= w_valid_next;
            r_illegal <= w_illegal_next;
            r_start   <= w_start_next;
            r_mdu_op  <= w_mdu_op_next;
            r_done    <= w_done_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign ALUOperation = OPER_WIDTH'(r_op);
    assign valid_o      = r_valid;
    assign Illegal      = r_illegal;
    assign MDUStart     = r_start;
    assign MDUOp        = r_mdu_op;
    assign MDUDone      = r_done;
    assign Stall        = (r_state == S_BUSY);

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq: default build plus a
// MULT_LATENCY=1 / OPER_WIDTH=6 build driven from the same inputs.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset, valid_i, flush_i;
    logic [2:0] alu_op;
    logic [5:0] funct;

    logic [3:0] op_a;
    logic       valid_a, ill_a, start_a, done_a, stall_a;
    logic [1:0] mduop_a;
    logic [5:0] op_b;
    logic       valid_b, ill_b, start_b, done_b, stall_b;
    logic [1:0] mduop_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_control_seq dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(alu_op), .ALUFunction(funct),
        .ALUOperation(op_a), .valid_o(valid_a), .Illegal(ill_a),
        .MDUStart(start_a), .MDUOp(mduop_a), .MDUDone(done_a), .Stall(stall_a)
    );

    alu_control_seq #(.MULT_LATENCY(1), .OPER_WIDTH(6)) dut1 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(alu_op), .ALUFunction(funct),
        .ALUOperation(op_b), .valid_o(valid_b), .Illegal(ill_b),
        .MDUStart(start_b), .MDUOp(mduop_b), .MDUDone(done_b), .Stall(stall_b)
    );

    typedef struct {
        logic [2:0] op;
        logic [5:0] f;
        logic [3:0] exp;
        logic       ill;
    } vec_t;

    vec_t vecs[15] = '{
        '{3'b111, 6'b100100, 4'b0000, 1'b0},
        '{3'b111, 6'b100101, 4'b0001, 1'b0},
        '{3'b111, 6'b100111, 4'b0010, 1'b0},
        '{3'b111, 6'b100010, 4'b0100, 1'b0},
        '{3'b111, 6'b000000, 4'b0110, 1'b0},
        '{3'b111, 6'b000010, 4'b0111, 1'b0},
        '{3'b111, 6'b101010, 4'b1000, 1'b0},
        '{3'b111, 6'b010000, 4'b1010, 1'b0},
        '{3'b111, 6'b010010, 4'b1011, 1'b0},
        '{3'b100, 6'b101010, 4'b0011, 1'b0},
        '{3'b001, 6'b000000, 4'b0001, 1'b0},
        '{3'b011, 6'b111111, 4'b0000, 1'b0},
        '{3'b101, 6'b011000, 4'b0101, 1'b0},
        '{3'b010, 6'b100000, 4'b0100, 1'b0},
        '{3'b111, 6'b111111, 4'b1001, 1'b1}
    };

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".op"},    32'(op_a),    32'h9);
        check({tag, ".valid"}, 32'(valid_a), 32'h0);
        check({tag, ".ill"},   32'(ill_a),   32'h0);
        check({tag, ".start"}, 32'(start_a), 32'h0);
        check({tag, ".mduop"}, 32'(mduop_a), 32'h0);
        check({tag, ".done"},  32'(done_a),  32'h0);
        check({tag, ".stall"}, 32'(stall_a), 32'h0);
    endtask

    initial begin
        reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; alu_op = 3'b000; funct = 6'b000000;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;

        // ADD
        valid_i = 1'b1; alu_op = 3'b111; funct = 6'b100000;
        tick();
        check("add.op",    32'(op_a),    32'h3);
        check("add.valid", 32'(valid_a), 32'h1);
        check("add.stall", 32'(stall_a), 32'h0);
        check("add.ill",   32'(ill_a),   32'h0);

        // Illegal ALUOp, then an idle cycle
        alu_op = 3'b110; funct = 6'b101101;
        tick();
        check("ill.op",    32'(op_a),    32'h9);
        check("ill.ill",   32'(ill_a),   32'h1);
        check("ill.valid", 32'(valid_a), 32'h1);
        valid_i = 1'b0;
        tick();
        check("idle.valid", 32'(valid_a), 32'h0);
        check("idle.ill",   32'(ill_a),   32'h0);
        check("idle.op",    32'(op_a),    32'h9);

        // Decode table
        valid_i = 1'b1;
        foreach (vecs[i]) begin
            alu_op = vecs[i].op; funct = vecs[i].f;
            tick();
            check($sformatf("dec%0d.op", i),  32'(op_a),  32'(vecs[i].exp));
            check($sformatf("dec%0d.ill", i), 32'(ill_a), 32'(vecs[i].ill));
        end

        // Flush in IDLE squashes the instruction
        alu_op = 3'b111; funct = 6'b100000; flush_i = 1'b1;
        tick();
        check("flush_idle.valid", 32'(valid_a), 32'h0);
        check("flush_idle.op",    32'(op_a),    32'h9);
        flush_i = 1'b0;

        // MULT, latency 4, SUB waiting upstream
        funct = 6'b011000;
        tick();
        check("mult.start", 32'(start_a), 32'h1);
        check("mult.mduop", 32'(mduop_a), 32'h0);
        check("mult.stall", 32'(stall_a), 32'h1);
        check("mult.op",    32'(op_a),    32'hc);
        check("mult.done0", 32'(done_a),  32'h0);
        funct = 6'b100010;
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("mult.stall%0d", i), 32'(stall_a), 32'h1);
            check($sformatf("mult.start%0d", i), 32'(start_a), 32'h0);
            check($sformatf("mult.done%0d", i),  32'(done_a),  32'(i == 3));
            check($sformatf("mult.hold%0d", i),  32'(op_a),    32'hc);
        end
        tick();
        check("mult.stall_end", 32'(stall_a), 32'h0);
        check("mult.done_end",  32'(done_a),  32'h0);
        tick();
        check("sub.op",    32'(op_a),    32'h4);
        check("sub.valid", 32'(valid_a), 32'h1);
        check("sub.stall", 32'(stall_a), 32'h0);

        // DIVU, latency 32, flush during the 3rd BUSY cycle
        funct = 6'b011011;
        tick();
        check("divu.start", 32'(start_a), 32'h1);
        check("divu.mduop", 32'(mduop_a), 32'h3);
        check("divu.stall", 32'(stall_a), 32'h1);
        valid_i = 1'b0;
        for (int i = 1; i < 32; i++) begin
            flush_i = (i == 3);
            tick();
            check($sformatf("divu.stall%0d", i), 32'(stall_a), 32'h1);
            check($sformatf("divu.done%0d", i),  32'(done_a),  32'(i == 31));
            check($sformatf("divu.valid%0d", i), 32'(valid_a), 32'(i < 3));
        end
        flush_i = 1'b0;
        tick();
        check("divu.stall_end", 32'(stall_a), 32'h0);
        check("divu.done_end",  32'(done_a),  32'h0);
        check("divu.mduop_hold", 32'(mduop_a), 32'h3);

        // DIV aborted by reset in BUSY cycle 5
        valid_i = 1'b1; funct = 6'b011010;
        tick();
        check("div.mduop", 32'(mduop_a), 32'h2);
        valid_i = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        check("div.stall5", 32'(stall_a), 32'h1);
        reset = 1'b1;
        tick();
        check_reset_state("div_reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("div.nodone%0d", i), 32'(done_a), 32'h0);
        end
        valid_i = 1'b1; alu_op = 3'b001; funct = 6'b000000;
        tick();
        check("ori.op",    32'(op_a),    32'h1);
        check("ori.valid", 32'(valid_a), 32'h1);

        // MULTU on the latency-1, 6-bit build
        alu_op = 3'b111; funct = 6'b011001;
        tick();
        check("l1.stall", 32'(stall_b), 32'h1);
        check("l1.start", 32'(start_b), 32'h1);
        check("l1.done",  32'(done_b),  32'h1);
        check("l1.op",    32'(op_b),    32'h0c);
        check("l1.mduop", 32'(mduop_b), 32'h1);
        valid_i = 1'b0;
        tick();
        check("l1.stall_end", 32'(stall_b), 32'h0);
        check("l1.start_end", 32'(start_b), 32'h0);
        check("l1.done_end",  32'(done_b),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
